// File: rtl/mult_div_unit_pkg.sv
// Shared op encodings and op classification for the EX-stage multiply/divide unit.
// Both the controller and the MD unit import these constants from here.
package mult_div_unit_pkg;

   localparam int MD_DW = 32;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

   typedef enum logic [1:0] {
      MD_SEL_NONE = 2'd0,
      MD_SEL_MUL  = 2'd1,
      MD_SEL_DIV  = 2'd2,
      MD_SEL_MOVE = 2'd3
   } md_sel_e;

   // Encodings 6 and 7 fall into MD_SEL_NONE so they issue as no-ops.
   function automatic md_sel_e md_classify(input logic [2:0] op);
      md_sel_e sel;
      case (op)
         MD_MULT, MD_MULTU: sel = MD_SEL_MUL;
         MD_DIV,  MD_DIVU:  sel = MD_SEL_DIV;
         MD_MTHI, MD_MTLO:  sel = MD_SEL_MOVE;
         default:           sel = MD_SEL_NONE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/mult_div_unit_md_latency_counter.sv
// Latency counter for long MD ops: loads N, counts down to zero, flags the final edge.
// busy is high exactly N cycles after the load edge.
module md_latency_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_n,
   output logic             o_busy,
   output logic             o_done
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_n;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign o_busy = (r_cnt != '0);
   // The next edge takes the count to zero: the parent commits on that edge.
   assign o_done = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit with HI/LO registers. Long ops run on latched operands
// and commit on the counter's final edge; MTHI/MTLO write in a single cycle.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] srcA,
   input  logic [31:0] srcB,
   input  logic        hilo_sel,
   output logic        busy,
   output logic [31:0] rd_data
);

   md_sel_e          w_sel;
   logic             w_accept;
   logic             w_load;
   logic             w_done;
   logic             w_commit;
   logic [CNT_W-1:0] w_load_n;
   logic [63:0]      w_result;

   logic [31:0]      r_a;
   logic [31:0]      r_b;
   md_op_e           r_op;
   logic [31:0]      r_hi;
   logic [31:0]      r_lo;

   function automatic logic [63:0] mul_signed(input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return 64'(sa * sb);
   endfunction

   function automatic logic [63:0] mul_unsigned(input logic [31:0] a, input logic [31:0] b);
      return {32'd0, a} * {32'd0, b};
   endfunction

   // Divides magnitudes so that 0x80000000 / -1 wraps to 0x80000000 instead of trapping.
   function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] ua, ub, uq, ur;
      ua = a[31] ? (~a + 32'd1) : a;
      ub = b[31] ? (~b + 32'd1) : b;
      uq = (ub == '0) ? '0 : ua / ub;
      ur = (ub == '0) ? '0 : ua % ub;
      if (a[31] ^ b[31]) uq = ~uq + 32'd1;
      if (a[31])         ur = ~ur + 32'd1;
      return {ur, uq};
   endfunction

   function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q, r;
      q = (b == '0) ? '0 : a / b;
      r = (b == '0) ? '0 : a % b;
      return {r, q};
   endfunction

   assign w_sel    = md_classify(op);
   assign w_accept = start & ~busy;
   assign w_load   = w_accept & ((w_sel == MD_SEL_MUL) | (w_sel == MD_SEL_DIV));
   assign w_load_n = (w_sel == MD_SEL_DIV) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

   md_latency_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .reset  (reset),
      .i_load (w_load),
      .i_n    (w_load_n),
      .o_busy (busy),
      .o_done (w_done)
   );

   // Operand capture: pure data, only meaningful once a long op has been loaded.
   always_ff @(posedge clk) begin
      if (w_load) begin
         r_a  <= srcA;
         r_b  <= srcB;
         r_op <= md_op_e'(op);
      end
   end

   always_comb begin
      w_result = '0;
      w_commit = 1'b0;
      case (r_op)
         MD_MULT: begin
            w_result = mul_signed(r_a, r_b);
            w_commit = w_done;
         end
         MD_MULTU: begin
            w_result = mul_unsigned(r_a, r_b);
            w_commit = w_done;
         end
         MD_DIV: begin
            w_result = div_signed(r_a, r_b);
            w_commit = w_done & (r_b != '0);
         end
         MD_DIVU: begin
            w_result = div_unsigned(r_a, r_b);
            w_commit = w_done & (r_b != '0);
         end
         default: begin
            w_result = '0;
            w_commit = 1'b0;
         end
      endcase
   end

   // Commit and move never coincide: commit needs busy=1, accept needs busy=0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (w_commit) begin
         r_hi <= w_result[63:32];
         r_lo <= w_result[31:0];
      end else if (w_accept && (w_sel == MD_SEL_MOVE)) begin
         if (op == MD_MTHI) r_hi <= srcA;
         else               r_lo <= srcA;
      end
   end

   assign rd_data = hilo_sel ? r_hi : r_lo;

endmodule
